// File: rtl/lpc_pkg.sv
// Shared LPC package: default frame/order/width constants and the
// autocorrelation control state encoding used by control and Levinson blocks.
package lpc_pkg;

    localparam int LPC_N  = 160;
    localparam int LPC_P  = 10;
    localparam int LPC_DW = 16;
    localparam int LPC_RW = 40;
    localparam int LPC_AW = 8;
    localparam int LPC_KW = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } lpc_state_e;

endpackage

// File: rtl/lpc_autocorrelation_if.sv
// Sample-memory read port pair and result-memory write port of the
// autocorrelation engine; master is the engine, slave the memories.
interface lpc_autocorrelation_if
    import lpc_pkg::*;
#(
    parameter int DW = LPC_DW,
    parameter int RW = LPC_RW,
    parameter int AW = LPC_AW
);
    logic        [AW-1:0]     x_raddr_a;
    logic        [AW-1:0]     x_raddr_b;
    logic signed [DW-1:0]     x_rdata_a;
    logic signed [DW-1:0]     x_rdata_b;
    logic                     r_wen;
    logic        [LPC_KW-1:0] r_waddr;
    logic signed [RW-1:0]     r_wdata;

    modport master (
        output x_raddr_a, x_raddr_b, r_wen, r_waddr, r_wdata,
        input  x_rdata_a, x_rdata_b
    );

    modport slave (
        input  x_raddr_a, x_raddr_b, r_wen, r_waddr, r_wdata,
        output x_rdata_a, x_rdata_b
    );
endinterface

// File: rtl/lpc_mac.sv
// Signed multiply-accumulate: full-precision DW x DW product sign-extended into
// an RW accumulator; clear has priority over enable.
module lpc_mac
    import lpc_pkg::*;
#(
    parameter int DW = LPC_DW,
    parameter int RW = LPC_RW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [RW-1:0] acc,
    output logic signed [RW-1:0] acc_next
);
    logic signed [2*DW-1:0] prod_s;
    logic signed [RW-1:0]   prod_ext_s;
    logic signed [RW-1:0]   acc_d;
    logic signed [RW-1:0]   acc_q;

    // Product and next accumulator value
    always_comb begin
        prod_s     = a * b;
        prod_ext_s = RW'(prod_s);
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = acc_q + prod_ext_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc      = acc_q;
    assign acc_next = acc_d;
endmodule

// File: rtl/lpc_autocorrelation.sv
// Frame autocorrelation R[0..P] over N samples via a dual-port sample read and lpc_mac.
// Optional build macro LPC_AUTOCORR_ZGUARD_EN forces R[0]=1 on an all-zero frame.
module lpc_autocorrelation
    import lpc_pkg::*;
#(
    parameter int N  = LPC_N,
    parameter int P  = LPC_P,
    parameter int DW = LPC_DW,
    parameter int RW = LPC_RW,
    parameter int AW = LPC_AW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ready,
    lpc_autocorrelation_if.master bus
);
    localparam logic [AW-1:0]     N_LAST = AW'(N - 1);
    localparam logic [LPC_KW-1:0] P_K    = LPC_KW'(P);

    lpc_state_e               state_q, state_d;
    logic        [LPC_KW-1:0] k_q, k_d;
    logic        [AW-1:0]     n_q, n_d;
    logic                     issue_prev_q, issue_prev_d;
    logic                     ready_q, ready_d;
    logic                     r_wen_q, r_wen_d;
    logic        [LPC_KW-1:0] r_waddr_q, r_waddr_d;
    logic signed [RW-1:0]     r_wdata_q, r_wdata_d;
    logic        [AW-1:0]     raddr_a_q, raddr_a_d;
    logic        [AW-1:0]     raddr_b_q, raddr_b_d;
    logic                     mac_clear_s;
    logic signed [RW-1:0]     acc_s;
    logic signed [RW-1:0]     acc_next_s;
    logic signed [RW-1:0]     wdata_s;

    // Read data returns one cycle after ISSUE, so the MAC is enabled from the delayed flag
    lpc_mac #(.DW(DW), .RW(RW)) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear    (mac_clear_s),
        .enable   (issue_prev_q),
        .a        (bus.x_rdata_a),
        .b        (bus.x_rdata_b),
        .acc      (acc_s),
        .acc_next (acc_next_s)
    );

    // Next-state, lag and sample index control
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        mac_clear_s = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = ISSUE;
                    k_d         = '0;
                    n_d         = '0;
                    mac_clear_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ISSUE: begin
                n_d = n_q + AW'(1);
                if (n_q == N_LAST) begin
                    state_d = DRAIN;
                end else begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                state_d = WRITE;
            end
            WRITE: begin
                if (k_q == P_K) begin
                    state_d = DONE;
                end else begin
                    state_d     = ISSUE;
                    k_d         = k_q + LPC_KW'(1);
                    n_d         = AW'(k_q + LPC_KW'(1));
                    mac_clear_s = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result value; acc_next already holds the final product when entering WRITE
    always_comb begin
`ifdef LPC_AUTOCORR_ZGUARD_EN
        if ((k_d == '0) && (acc_next_s == '0)) begin
            wdata_s = RW'(1);
        end else begin
            wdata_s = acc_next_s;
        end
`else
        wdata_s = acc_next_s;
`endif
    end

    // Registered outputs are derived from the next state so they align with it
    always_comb begin
        issue_prev_d = (state_q == ISSUE);
        ready_d      = (state_d == DONE);
        if (state_d == ISSUE) begin
            raddr_a_d = n_d;
            raddr_b_d = n_d - AW'(k_d);
        end else begin
            raddr_a_d = '0;
            raddr_b_d = '0;
        end
        if (state_d == WRITE) begin
            r_wen_d   = 1'b1;
            r_waddr_d = k_d;
            r_wdata_d = wdata_s;
        end else begin
            r_wen_d   = 1'b0;
            r_waddr_d = '0;
            r_wdata_d = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            n_q          <= '0;
            issue_prev_q <= 1'b0;
            ready_q      <= 1'b0;
            r_wen_q      <= 1'b0;
            r_waddr_q    <= '0;
            r_wdata_q    <= '0;
            raddr_a_q    <= '0;
            raddr_b_q    <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            n_q          <= n_d;
            issue_prev_q <= issue_prev_d;
            ready_q      <= ready_d;
            r_wen_q      <= r_wen_d;
            r_waddr_q    <= r_waddr_d;
            r_wdata_q    <= r_wdata_d;
            raddr_a_q    <= raddr_a_d;
            raddr_b_q    <= raddr_b_d;
        end
    end

    assign ready         = ready_q;
    assign bus.x_raddr_a = raddr_a_q;
    assign bus.x_raddr_b = raddr_b_q;
    assign bus.r_wen     = r_wen_q;
    assign bus.r_waddr   = r_waddr_q;
    assign bus.r_wdata   = r_wdata_q;
endmodule

// File: tb/tb_lpc_autocorrelation.sv
// Directed bench for lpc_autocorrelation at default parameters with a
// behavioural dual-port sample memory and a result-write logger.
module tb_lpc_autocorrelation;
    logic clk = 1'b0;
    logic reset;
    logic start;
    logic ready;
    int   checks = 0;
    int   errors = 0;
    int   wcount = 0;

    logic signed [15:0] x_mem    [0:255];
    logic signed [39:0] got_val  [0:511];
    logic        [3:0]  got_addr [0:511];

    always #5 clk = ~clk;

    lpc_autocorrelation_if #(.DW(16), .RW(40), .AW(8)) bus ();

    lpc_autocorrelation #(.N(160), .P(10), .DW(16), .RW(40), .AW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .ready (ready),
        .bus   (bus)
    );

    always @(posedge clk) begin
        bus.x_rdata_a <= x_mem[bus.x_raddr_a];
        bus.x_rdata_b <= x_mem[bus.x_raddr_b];
    end

    always @(negedge clk) begin
        if (bus.r_wen === 1'b1) begin
            if (wcount < 512) begin
                got_val[wcount]  <= bus.r_wdata;
                got_addr[wcount] <= bus.r_waddr;
            end
            wcount <= wcount + 1;
        end
    end

    // mode 0: ones, 1: (-1)^n, 2: -32768, 3: zeros, 4: twos
    task automatic fill(input int mode);
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0:       x_mem[i] = 16'sd1;
                1:       x_mem[i] = (i % 2 == 0) ? 16'sd1 : -16'sd1;
                2:       x_mem[i] = -16'sd32768;
                3:       x_mem[i] = 16'sd0;
                default: x_mem[i] = 16'sd2;
            endcase
        end
    endtask

    function automatic longint expected(input int mode, input int k);
        longint m;
        m = 64'(160 - k);
        case (mode)
            0: return m;
            1: return (k % 2 == 0) ? m : -m;
            2: return m * 64'sd1073741824;
            3: begin
`ifdef LPC_AUTOCORR_ZGUARD_EN
                return (k == 0) ? 64'sd1 : 64'sd0;
`else
                return 64'sd0;
`endif
            end
            default: return 64'sd4 * m;
        endcase
    endfunction

    task automatic run_frame(output int cycles, output int base);
        base = wcount;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        while (ready !== 1'b1 && cycles < 4000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        checks++; if (bus.r_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b want 0", bus.r_wen); end
        checks++; if (bus.r_waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", bus.r_waddr); end
        checks++; if (bus.r_wdata !== 40'sd0) begin errors++; $display("FAIL reset_wdata got %0d want 0", bus.r_wdata); end
        checks++; if (bus.x_raddr_a !== 8'd0) begin errors++; $display("FAIL reset_raddr_a got %0d want 0", bus.x_raddr_a); end
        checks++; if (bus.x_raddr_b !== 8'd0) begin errors++; $display("FAIL reset_raddr_b got %0d want 0", bus.x_raddr_b); end
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_pattern(input string name, input int mode, input bit check_time);
        int cycles, base;
        fill(mode);
        run_frame(cycles, base);
        checks++; if (cycles >= 4000) begin errors++; $display("FAIL %s_timeout got %0d cycles want ready", name, cycles); end
        if (check_time) begin
            checks++; if (cycles != 1727) begin errors++; $display("FAIL %s_latency got %0d want 1727", name, cycles); end
        end
        checks++; if (wcount - base != 11) begin errors++; $display("FAIL %s_writes got %0d want 11", name, wcount - base); end
        for (int k = 0; k <= 10; k++) begin
            checks++;
            if (got_addr[base + k] !== 4'(k) || longint'(got_val[base + k]) !== expected(mode, k)) begin
                errors++;
                $display("FAIL %s_R%0d got addr %0d val %0d want addr %0d val %0d",
                         name, k, got_addr[base + k], got_val[base + k], k, expected(mode, k));
            end
        end
    endtask

    task automatic test_reset_mid;
        int base, held;
        fill(0);
        base = wcount;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (500) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.r_wen !== 1'b0) begin errors++; $display("FAIL midreset_wen got %b want 0", bus.r_wen); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %b want 0", ready); end
        checks++; if (bus.x_raddr_a !== 8'd0) begin errors++; $display("FAIL midreset_raddr got %0d want 0", bus.x_raddr_a); end
        held = wcount;
        repeat (4) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (wcount != held) begin errors++; $display("FAIL midreset_nowrite got %0d want %0d", wcount, held); end
        checks++; if (held - base != 3) begin errors++; $display("FAIL midreset_prewrites got %0d want 3", held - base); end
        test_pattern("after_reset", 0, 1'b1);
    endtask

    task automatic test_start_issue;
        int cycles, base;
        fill(0);
        base = wcount;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        while (ready !== 1'b1 && cycles < 4000) begin
            @(posedge clk);
            #1;
            cycles++;
            start = (cycles == 50);
        end
        start = 1'b0;
        @(negedge clk);
        checks++; if (cycles != 1727) begin errors++; $display("FAIL start_issue_latency got %0d want 1727", cycles); end
        checks++; if (wcount - base != 11) begin errors++; $display("FAIL start_issue_writes got %0d want 11", wcount - base); end
        checks++;
        if (longint'(got_val[base + 10]) !== 64'sd150) begin
            errors++;
            $display("FAIL start_issue_R10 got %0d want 150", got_val[base + 10]);
        end
    endtask

    task automatic test_start_done;
        int cycles, base;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL done_pre_ready got %b want 1", ready); end
        fill(4);
        base = wcount;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL done_ready_drop got %b want 0", ready); end
        cycles = 0;
        while (ready !== 1'b1 && cycles < 4000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        @(negedge clk);
        checks++; if (cycles != 1727) begin errors++; $display("FAIL done_latency got %0d want 1727", cycles); end
        checks++; if (wcount - base != 11) begin errors++; $display("FAIL done_writes got %0d want 11", wcount - base); end
        for (int k = 0; k <= 10; k++) begin
            checks++;
            if (longint'(got_val[base + k]) !== expected(4, k)) begin
                errors++;
                $display("FAIL done_R%0d got %0d want %0d", k, got_val[base + k], expected(4, k));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill(3);
        test_reset;
        test_pattern("ones", 0, 1'b1);
        test_pattern("alt", 1, 1'b0);
        test_pattern("negfull", 2, 1'b0);
        test_pattern("zero", 3, 1'b0);
        test_reset_mid;
        test_start_issue;
        test_start_done;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lpc_autocorrelation.md
LPC_AUTOCORRELATION -- requirements
Module: lpc_autocorrelation

Interface
REQ-001 SHALL have parameter N, default 160: frame length in samples.
REQ-002 SHALL have parameter P, default 10: LPC order; lags 0..P are produced.
REQ-003 SHALL have parameter DW, default 16: signed sample width.
REQ-004 SHALL have parameter RW, default 40: signed result and accumulator width.
REQ-005 SHALL have parameter AW, default 8: sample address width; N <= 2^AW.
REQ-006 SHALL have port clk  in  1  clock; all logic is rising-edge.
REQ-007 SHALL have port reset  in  1  reset: synchronous, active-high.
REQ-008 SHALL have port start  in  1  one-cycle pulse that begins a frame.
REQ-009 SHALL have ports x_raddr_a and x_raddr_b  out  AW  two sample-memory read addresses.
REQ-010 SHALL have ports x_rdata_a and x_rdata_b  in  DW  read data for those addresses; valid one cycle after the address.
REQ-011 SHALL have port r_wen  out  1  result-memory write strobe.
REQ-012 SHALL have port r_waddr  out  4  result index k.
REQ-013 SHALL have port r_wdata  out  RW  value R[k].
REQ-014 SHALL have port ready  out  1  level; all R[0..P] have been written.

Function
REQ-015 SHALL compute R[k] = sum over n=k..N-1 of x[n]*x[n-k] for k=0..P, with signed arithmetic and no truncation inside RW.
REQ-016 SHALL use the FSM states IDLE, ISSUE, DRAIN, WRITE and DONE.
REQ-017 IDLE SHALL, when start=1, load k=0, n=0 and acc=0, then go to ISSUE.
REQ-018 ISSUE SHALL drive x_raddr_a=n and x_raddr_b=n-k, increment n, and go to DRAIN after issuing n=N-1.
REQ-019 In ISSUE and DRAIN, acc SHALL add x_rdata_a*x_rdata_b of the previous cycle whenever the previous cycle was ISSUE.
REQ-020 DRAIN SHALL last one cycle and then go to WRITE.
REQ-021 WRITE SHALL assert r_wen=1 for one cycle with r_waddr=k and r_wdata=acc.
REQ-022 After WRITE, the FSM SHALL go to DONE if k=P; otherwise it SHALL set k=k+1, n=k+1 and acc=0, then go to ISSUE.
REQ-023 DONE SHALL hold ready=1; when start=1 it SHALL restart exactly as from IDLE, and ready SHALL drop on the next cycle.
REQ-024 Lag k SHALL take N-k+2 cycles; total time from the first ISSUE cycle to ready=1 SHALL be (P+1)(N+2)-P(P+1)/2 cycles, which is 1727 at defaults.
REQ-025 A start pulse in ISSUE, DRAIN or WRITE SHALL be ignored.
REQ-026 Outside WRITE, r_wen SHALL be 0; addresses SHALL be 0 outside ISSUE.

Reset
REQ-027 While reset=1, the FSM SHALL go to IDLE and ready, r_wen, r_waddr, r_wdata, x_raddr_a, x_raddr_b, acc, k and n SHALL all be 0.
REQ-028 Reset mid-frame SHALL abort without further writes; a following start SHALL produce a complete, correct frame.

Configuration
REQ-029 With LPC_AUTOCORR_ZGUARD_EN defined, WRITE for k=0 with acc=0 SHALL emit r_wdata=1, preventing a divide-by-zero in Levinson on silent frames.
REQ-030 Without LPC_AUTOCORR_ZGUARD_EN, R[0] SHALL be written unmodified; no guard logic SHALL exist.

Structure
REQ-031 The state encoding and default N/P/DW/RW constants SHALL live in shared package lpc_pkg, which the control and Levinson blocks also use.
REQ-032 The multiply-accumulate SHALL be sub-module lpc_mac, with clear, enable, two DW inputs and an RW accumulator output.

Verification
REQ-033 x[n]=1 for all n at defaults -> R[k]=160-k (R[0]=160, R[10]=150), written in order k=0..10, ready at cycle 1727 after the first ISSUE.
REQ-034 x[n]=(-1)^n -> R[k]=(160-k)*(-1)^k, e.g. R[1]=-159, R[2]=158.
REQ-035 x[n]=-32768 for all n -> R[0]=171798691840 with no overflow; R[10]=161061273600.
REQ-036 All-zero frame -> R[0]=1 with LPC_AUTOCORR_ZGUARD_EN and 0 without it; R[1..10]=0 in both builds.
REQ-037 Reset held at cycle 500 of a frame -> next cycle r_wen=0 and ready=0; a new start then yields the REQ-033 results.
REQ-038 start pulsed during ISSUE -> no effect and the same count of 11 writes; start in DONE -> ready=0 next cycle and a full recompute.
